// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and sizes for the data-memory access controller and the memory it drives.
// Latency: none (declarations only).
// Backpressure: n/a.
package dm_access_pkg;

    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 32;
    localparam int DM_DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Bundles the core request/response channels and the data-memory pins.
// Latency: none (wiring only).
// Backpressure: req_ready/rsp_ready carry the valid-ready handshakes.
interface dm_access_ctrl_if
    import dm_access_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_add;
    logic [DATA_W-1:0] dm_data;
    logic [DATA_W-1:0] dm_out;

    // Environment side: the core issuing requests plus the memory returning read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, dm_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_add, dm_data
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dm_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_we, dm_add, dm_data
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Sequences load/store requests onto a single-port registered-read data memory (optional DM_ACCESS_CTRL_BOUNDS_CHECK_EN).
// Latency: response valid 2 cycles after accept for stores, 3 for loads, 1 for out-of-range when bounds check is built in.
// Backpressure: response held in RESP while rsp_ready=0; req_ready low except in IDLE or a completing RESP.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ADDR_W    = DM_ADDR_W,
    parameter int DATA_W    = DM_DATA_W,
    parameter int MEM_DEPTH = DM_DEPTH
)
(
    input  logic           clk,
    input  logic           rst_n,
    dm_access_ctrl_if.slave bus
);

`ifdef DM_ACCESS_CTRL_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);

    state_t            state;
    state_t            nextState;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              errQ;
    logic              reqReady;
    logic              rspValid;
    logic              dmWe;
    logic              accept;
    logic              outOfRange;

    // Out-of-range requests never reach the memory; constant-false when the check is not built in.
    assign outOfRange = BOUNDS_EN && (bus.req_addr >= DEPTH_LIM);

    // Next state plus handshake and write-strobe decode; all outputs come from state except req_ready's rsp_ready term.
    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        rspValid  = 1'b0;
        dmWe      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                reqReady = 1'b1;
                accept   = bus.req_valid;
                if (accept) nextState = outOfRange ? RESP : ISSUE;
            end
            ISSUE: begin
                dmWe      = weQ;
                nextState = weQ ? RESP : CAPTURE;
            end
            CAPTURE: begin
                nextState = RESP;
            end
            RESP: begin
                rspValid = 1'b1;
                reqReady = bus.rsp_ready;
                accept   = bus.req_valid && bus.rsp_ready;
                if (bus.rsp_ready) begin
                    if (accept) nextState = outOfRange ? RESP : ISSUE;
                    else        nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register; async reset drops dm_we at once because dm_we decodes from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Request capture; address/data only move for issued requests so the memory pins do not toggle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (accept) begin
            weQ <= bus.req_we;
            if (!outOfRange) begin
                addrQ  <= bus.req_addr;
                wdataQ <= bus.req_wdata;
            end
        end
    end

    // Response payload; loaded only when entering RESP, so it stays stable through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else if (accept && outOfRange) begin
            rdataQ <= '0;
            errQ   <= 1'b1;
        end else if (state == ISSUE && weQ) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else if (state == CAPTURE) begin
            rdataQ <= bus.dm_out;
            errQ   <= 1'b0;
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_rdata = rdataQ;
    assign bus.rsp_err   = errQ;
    assign bus.dm_we     = dmWe;
    assign bus.dm_add    = addrQ;
    assign bus.dm_data   = wdataQ;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller for the single-port data memory (synchronous write, registered read on posedge clk, `we_DM` selects write vs read).
- Takes load/store requests from the core over a valid/ready handshake.
- Sequences the memory's `we_DM`/`addDM`/`dataDM` pins, absorbs the one-cycle registered-read latency, and returns read data and status over a valid/ready response channel.

Parameters:
- ADDR_W, 12, width of request and memory address.
- DATA_W, 32, data word width.
- MEM_DEPTH, 32, number of implemented memory words; valid addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_W  load data; 0 for stores.
- rsp_err  out  1  error status; see Optional Feature.
- dm_we  out  1  to memory `we_DM`.
- dm_add  out  ADDR_W  to memory `addDM`.
- dm_data  out  DATA_W  to memory `dataDM`.
- dm_out  in  DATA_W  from memory `outDM`.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - dm_we=0, dm_add=0, dm_data=0.
  - All internal request registers cleared.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1; dm_we=0.
  - On req_valid&req_ready at edge E0: latch we, addr, wdata; go to ISSUE.
- ISSUE (one cycle):
  - dm_add=addr_q, dm_data=wdata_q, dm_we=we_q. The memory acts at edge E1.
  - Store: go to RESP with rsp_rdata=0.
  - Load: go to CAPTURE.
- CAPTURE (load only, one cycle):
  - dm_we=0, dm_add held at addr_q; dm_out now carries mem[addr_q].
  - At edge E2: rsp_rdata<=dm_out; go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - On handshake: if req_valid in the same cycle, accept it (go to ISSUE); otherwise go to IDLE.
- Latency:
  - rsp_valid first high in the cycle after E1 (store) or E2 (load).
  - Back-to-back throughput: 2 cycles per store, 3 per load, when rsp_ready is held 1.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). This is combinational from rsp_ready; there is no other combinational path.
- dm_we=1 is asserted for exactly one cycle per store and never during loads or in IDLE/RESP.
- dm_add and dm_data hold their last driven values outside ISSUE/CAPTURE. This avoids spurious address toggles.
- Backpressure: rsp_ready held 0 stalls in RESP indefinitely; req_ready=0 throughout.
- A request presented while req_ready=0 is ignored and must be held by the core.
- Reset mid-operation:
  - Reset asserted during ISSUE forces dm_we=0 immediately. The store does not occur if reset is still asserted at the edge.
  - Any pending response is discarded.
- Address wrap: no wrap; addresses are passed through unmodified unless the bounds check is compiled in.

Optional Feature:
- Macro: DM_ACCESS_CTRL_BOUNDS_CHECK_EN.
- With the macro defined:
  - A request with req_addr >= MEM_DEPTH skips ISSUE/CAPTURE and goes IDLE -> RESP directly.
  - dm_we stays 0, rsp_rdata=0, rsp_err=1.
  - In-range requests behave as described above with rsp_err=0.
- Without the macro: rsp_err is tied 0 and all addresses are issued to memory.

Decomposition:
- Shared package dm_access_pkg:
  - state enum {IDLE, ISSUE, CAPTURE, RESP};
  - localparams DM_ADDR_W=12, DM_DATA_W=32, DM_DEPTH=32, shared with the memory block.
- No sub-module is required. The bounds comparator is a single inline compare.

Test Plan:
- Store then load: store addr 5 data 0xDEADBEEF, then load addr 5 -> dm_we high exactly one cycle with dm_add=5; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
- Backpressure: load addr 5 with rsp_ready=0 for 10 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready=0; release -> single handshake, then IDLE.
- Back-to-back: stores to addrs 0..3 with data 0x10..0x13 and rsp_ready=1 -> one store issued every 2 cycles; subsequent loads of 0..3 return 0x10..0x13 in order.
- Reset mid-store: assert rst_n=0 during ISSUE of a store to addr 7 data 0x55 -> dm_we drops immediately; load of addr 7 afterwards returns its prior value, not 0x55.
- Bounds (macro on): load addr 40 -> no memory access (dm_we=0, dm_add unchanged), rsp_err=1, rsp_rdata=0, rsp_valid after 1 cycle. Macro off: same stimulus gives dm_add=40 and rsp_err=0.
- Simultaneous response and request: in RESP with rsp_ready=1 and req_valid=1 (load addr 2) -> request accepted that cycle and ISSUE follows immediately with no IDLE cycle.
